qtable_best_hop_reader: RTL and testbench

- Read-side companion to the Q-table update logic.
- On request, scans the neighbor Q-table held in the shared 2048x16 memory and selects the neighbor with the highest Q-value.
- Fetches that neighbor's node ID, energy and cluster ID, then presents them to the routing/transmit logic as the chosen next hop.
- Sits beside the updater on the same memory port. Arbitration is external, and this block never writes.

---
 rtl/qtable_best_hop_reader_if.sv | 31 +++
 rtl/qtable_best_hop_reader.sv | 142 ++++++++++++++
 tb/tb_qtable_best_hop_reader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/qtable_best_hop_reader_if.sv
// Request/result and memory-port bundle for the best-hop reader.
// slave: the reader itself. master: the requester plus the memory-side driver.
interface qtable_best_hop_reader_if #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 11
);
    logic                  en;
    logic [4:0]            neighbor_count;
    logic [ADDR_WIDTH-1:0] address;
    logic                  wr_en;
    logic [WORD_WIDTH-1:0] data_in;
    logic                  busy;
    logic                  done;
    logic                  found;
    logic [WORD_WIDTH-1:0] best_id;
    logic [WORD_WIDTH-1:0] best_energy;
    logic [WORD_WIDTH-1:0] best_q;
    logic [WORD_WIDTH-1:0] best_cluster;

    modport master (
        output en, neighbor_count, data_in,
        input  address, wr_en, busy, done, found,
        input  best_id, best_energy, best_q, best_cluster
    );

    modport slave (
        input  en, neighbor_count, data_in,
        output address, wr_en, busy, done, found,
        output best_id, best_energy, best_q, best_cluster
    );
endinterface

// File: rtl/qtable_best_hop_reader.sv
// Scans the neighbor Q-table for the highest Q-value, then fetches that
// neighbor's ID, energy and cluster fields. Read-only on the shared memory.
module qtable_best_hop_reader #(
    parameter int unsigned           WORD_WIDTH    = 16,
    parameter int unsigned           ADDR_WIDTH    = 11,
    parameter logic [ADDR_WIDTH-1:0] TABLE_BASE    = 11'h100,
    parameter int unsigned           MAX_NEIGHBORS = 16
) (
    input logic                     clock,
    input logic                     nrst,
    qtable_best_hop_reader_if.slave bus
);

    localparam logic [4:0] MAX_CNT = 5'(MAX_NEIGHBORS);

    typedef enum logic [3:0] {
        StIdle, StQAddr, StQData, StIdAddr, StIdData,
        StEnAddr, StEnData, StClAddr, StClData, StDone
    } state_e;

    state_e                state_q, state_d;
    logic [4:0]            i_q, i_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [4:0]            best_idx_q, best_idx_d;
    logic [WORD_WIDTH-1:0] best_qval_q, best_qval_d;
    logic [WORD_WIDTH-1:0] best_id_q, best_id_d;
    logic [WORD_WIDTH-1:0] best_energy_q, best_energy_d;
    logic [WORD_WIDTH-1:0] best_cluster_q, best_cluster_d;
    logic                  found_q, found_d;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] q_addr;
    logic [ADDR_WIDTH-1:0] fetch_base;

    assign q_addr     = TABLE_BASE + (ADDR_WIDTH'(i_q) << 2) + ADDR_WIDTH'(2);
    assign fetch_base = TABLE_BASE + (ADDR_WIDTH'(best_idx_q) << 2);

    // Next-state, datapath updates and memory address.
    always_comb begin
        state_d        = state_q;
        i_d            = i_q;
        cnt_d          = cnt_q;
        best_idx_d     = best_idx_q;
        best_qval_d    = best_qval_q;
        best_id_d      = best_id_q;
        best_energy_d  = best_energy_q;
        best_cluster_d = best_cluster_q;
        found_d        = found_q;
        addr           = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.en) begin
                    cnt_d       = (bus.neighbor_count > MAX_CNT) ? MAX_CNT : bus.neighbor_count;
                    i_d         = '0;
                    best_idx_d  = '0;
                    best_qval_d = '0;
                    found_d     = 1'b0;
                    state_d     = (cnt_d == '0) ? StDone : StQAddr;
                end
            end
            StQAddr: begin
                addr    = q_addr;
                state_d = StQData;
            end
            StQData: begin
                // Strictly greater keeps the lowest index on ties.
                if (i_q == '0 || bus.data_in > best_qval_q) begin
                    best_qval_d = bus.data_in;
                    best_idx_d  = i_q;
                end
                i_d     = i_q + 5'd1;
                state_d = (i_d == cnt_q) ? StIdAddr : StQAddr;
            end
            StIdAddr: begin
                addr    = fetch_base;
                state_d = StIdData;
            end
            StIdData: begin
                best_id_d = bus.data_in;
                state_d   = StEnAddr;
            end
            StEnAddr: begin
                addr    = fetch_base + ADDR_WIDTH'(1);
                state_d = StEnData;
            end
            StEnData: begin
                best_energy_d = bus.data_in;
                state_d       = StClAddr;
            end
            StClAddr: begin
                addr    = fetch_base + ADDR_WIDTH'(3);
                state_d = StClData;
            end
            StClData: begin
                best_cluster_d = bus.data_in;
                found_d        = 1'b1;
                state_d        = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q        <= StIdle;
            i_q            <= '0;
            cnt_q          <= '0;
            best_idx_q     <= '0;
            best_qval_q    <= '0;
            best_id_q      <= '0;
            best_energy_q  <= '0;
            best_cluster_q <= '0;
            found_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            i_q            <= i_d;
            cnt_q          <= cnt_d;
            best_idx_q     <= best_idx_d;
            best_qval_q    <= best_qval_d;
            best_id_q      <= best_id_d;
            best_energy_q  <= best_energy_d;
            best_cluster_q <= best_cluster_d;
            found_q        <= found_d;
        end
    end

    assign bus.address      = addr;
    assign bus.wr_en        = 1'b0;
    assign bus.busy         = (state_q != StIdle) && (state_q != StDone);
    assign bus.done         = (state_q == StDone);
    assign bus.found        = found_q;
    assign bus.best_id      = best_id_q;
    assign bus.best_energy  = best_energy_q;
    assign bus.best_q       = best_qval_q;
    assign bus.best_cluster = best_cluster_q;

endmodule

// File: tb/tb_qtable_best_hop_reader.sv
// Bench for qtable_best_hop_reader: directed cases plus randomized tables,
// checked against an argmax reference computed straight from the table contents.
module tb_qtable_best_hop_reader;

    localparam int BASE = 'h100;

    logic clock;
    logic nrst;
    logic [15:0] mem [0:2047];

    int n_cmp = 0;
    int n_bad = 0;
    int done_pulses = 0;
    int wr_bad = 0;
    int busy_seen = 0;
    int addr_nz = 0;
    int last_q_addr = 0;

    // Model state carried across scans (fetched fields hold when count is 0).
    logic [15:0] exp_id = '0;
    logic [15:0] exp_energy = '0;
    logic [15:0] exp_cluster = '0;

    qtable_best_hop_reader_if #(.WORD_WIDTH(16), .ADDR_WIDTH(11)) bus ();

    qtable_best_hop_reader dut (
        .clock (clock),
        .nrst  (nrst),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read memory model.
    always @(posedge clock) bus.data_in <= mem[bus.address];

    // Observe activity between checkpoints.
    always @(negedge clock) begin
        if (bus.done === 1'b1) done_pulses++;
        if (bus.wr_en !== 1'b0) wr_bad++;
        if (bus.busy === 1'b1) busy_seen = 1;
        if (bus.address !== '0) addr_nz = 1;
        if (bus.address[1:0] == 2'b10) last_q_addr = int'(bus.address);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put_entry(input int i, input logic [15:0] id, input logic [15:0] en,
                             input logic [15:0] q, input logic [15:0] cl);
        mem[BASE + 4*i + 0] = id;
        mem[BASE + 4*i + 1] = en;
        mem[BASE + 4*i + 2] = q;
        mem[BASE + 4*i + 3] = cl;
    endtask

    // Reference: clamp count, then take the first index holding the maximum Q.
    function automatic void ref_scan(input int n, output int cnt, output int bi);
        cnt = (n > 16) ? 16 : n;
        bi = 0;
        for (int k = 1; k < cnt; k++)
            if (mem[BASE + 4*k + 2] > mem[BASE + 4*bi + 2]) bi = k;
    endfunction

    task automatic scan_and_check(input int n, input bit repulse, input bit wiggle,
                                  input bit done_en);
        int cnt, bi, edges, exp_edges;
        logic [15:0] exp_q;
        ref_scan(n, cnt, bi);
        exp_q = '0;
        if (cnt != 0) begin
            exp_q       = mem[BASE + 4*bi + 2];
            exp_id      = mem[BASE + 4*bi + 0];
            exp_energy  = mem[BASE + 4*bi + 1];
            exp_cluster = mem[BASE + 4*bi + 3];
        end
        exp_edges = (cnt == 0) ? 1 : 2*cnt + 7;

        @(negedge clock);
        done_pulses = 0; busy_seen = 0; addr_nz = 0; last_q_addr = 0;
        bus.en = 1'b1;
        bus.neighbor_count = 5'(n);
        @(negedge clock);
        bus.en = 1'b0;
        edges = 1;
        chk("found_clear_after_en", bus.found, 1'b0);
        chk("busy_after_en", bus.busy, (cnt != 0));
        while (bus.done !== 1'b1 && edges < 100) begin
            bus.en = (repulse && edges == 3) ? 1'b1 : 1'b0;
            if (wiggle) bus.neighbor_count = 5'($urandom);
            @(negedge clock);
            edges++;
        end
        bus.en = 1'b0;
        chk("done_latency", edges, exp_edges);
        chk("done", bus.done, 1'b1);
        chk("busy_in_done", bus.busy, 1'b0);
        chk("found", bus.found, (cnt != 0));
        chk("best_q", bus.best_q, exp_q);
        chk("best_id", bus.best_id, exp_id);
        chk("best_energy", bus.best_energy, exp_energy);
        chk("best_cluster", bus.best_cluster, exp_cluster);
        if (done_en) begin
            bus.en = 1'b1;
            @(negedge clock);
            bus.en = 1'b0;
            chk("en_in_done_ignored", bus.busy, 1'b0);
        end
        repeat (3) @(negedge clock);
        chk("single_done_pulse", done_pulses, 1);
        chk("found_held", bus.found, (cnt != 0));
        chk("best_id_held", bus.best_id, exp_id);
        if (cnt == 0) begin
            chk("busy_never_high", busy_seen, 0);
            chk("address_stays_0", addr_nz, 0);
        end else begin
            chk("last_q_addr", last_q_addr, BASE + 4*(cnt-1) + 2);
        end
        chk("wr_en_zero", wr_bad, 0);
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) mem[a] = '0;
        nrst = 1'b0;
        bus.en = 1'b0;
        bus.neighbor_count = '0;
        #1;
        chk("rst_address", bus.address, '0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_found", bus.found, 1'b0);
        chk("rst_best_q", bus.best_q, '0);
        chk("rst_best_id", bus.best_id, '0);
        repeat (2) @(negedge clock);
        nrst = 1'b1;

        // Three entries, unique maximum at entry 1.
        put_entry(0, 16'd5,  16'h7F00, 16'h0100, 16'd2);
        put_entry(1, 16'd9,  16'h6A00, 16'h0480, 16'd3);
        put_entry(2, 16'd12, 16'h5000, 16'h0200, 16'd3);
        scan_and_check(3, 1'b0, 1'b0, 1'b0);
        chk("plan_best_id", bus.best_id, 16'd9);
        chk("plan_best_q", bus.best_q, 16'h0480);

        // Tie keeps the lowest index.
        put_entry(0, 16'd4, 16'h1111, 16'h0300, 16'd7);
        put_entry(1, 16'd6, 16'h2222, 16'h0300, 16'd8);
        scan_and_check(2, 1'b0, 1'b0, 1'b0);
        chk("tie_best_id", bus.best_id, 16'd4);

        // Empty table.
        scan_and_check(0, 1'b0, 1'b0, 1'b0);

        // Clamp to 16 entries; unsigned compare against 0x8000 entries.
        for (int k = 0; k < 16; k++)
            put_entry(k, 16'(100 + k), 16'($urandom), (k % 2) ? 16'h8000 : 16'h0010, 16'(k));
        put_entry(15, 16'd77, 16'h4321, 16'hFFFF, 16'd5);
        scan_and_check(20, 1'b0, 1'b1, 1'b0);
        chk("clamp_best_id", bus.best_id, 16'd77);

        // en while busy and en in the DONE cycle are ignored; then a fresh scan.
        put_entry(0, 16'd5,  16'h7F00, 16'h0100, 16'd2);
        put_entry(1, 16'd9,  16'h6A00, 16'h0480, 16'd3);
        put_entry(2, 16'd12, 16'h5000, 16'h0200, 16'd3);
        scan_and_check(3, 1'b1, 1'b0, 1'b1);
        scan_and_check(3, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a scan.
        @(negedge clock);
        done_pulses = 0;
        bus.en = 1'b1;
        bus.neighbor_count = 5'd3;
        @(negedge clock);
        bus.en = 1'b0;
        repeat (3) @(negedge clock);
        nrst = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_address", bus.address, '0);
        chk("midrst_found", bus.found, 1'b0);
        chk("midrst_best_q", bus.best_q, '0);
        chk("midrst_best_id", bus.best_id, '0);
        chk("midrst_best_energy", bus.best_energy, '0);
        chk("midrst_best_cluster", bus.best_cluster, '0);
        repeat (3) @(negedge clock);
        chk("midrst_no_done", done_pulses, 0);
        nrst = 1'b1;
        exp_id = '0; exp_energy = '0; exp_cluster = '0;
        scan_and_check(1, 1'b0, 1'b0, 1'b0);

        // Randomized tables, counts and Q patterns (small value set forces ties).
        for (int t = 0; t < 10; t++) begin
            for (int k = 0; k < 16; k++) begin
                logic [15:0] q;
                logic [1:0] pick;
                pick = 2'($urandom);
                if ($urandom_range(0, 1) == 0)
                    q = (pick == 0) ? 16'h0000 : (pick == 1) ? 16'h8000 :
                        (pick == 2) ? 16'hFFFF : 16'h0300;
                else
                    q = 16'($urandom);
                put_entry(k, 16'($urandom), 16'($urandom), q, 16'($urandom));
            end
            scan_and_check(int'($urandom_range(0, 20)), t[0], t[1], t[2]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
